// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// Packet-level round-robin arbiter that shares one UART transmit path between
// NUM_REQ byte-stream requesters. Each granted packet goes out as a frame:
//   SYNC_BYTE, ID byte (ID_BASE + requester index), payload bytes
// and, when the UART_ARB_CHECKSUM_EN macro is defined, one trailing XOR
// checksum byte covering the ID byte and the payload.
// A granted requester that leaves req_valid low for STALL_TIMEOUT stall cycles
// mid-payload loses the link: the frame is dropped and abort_pulse fires.
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ       = 2,
  parameter logic [7:0]  SYNC_BYTE     = 8'hA5,
  parameter logic [7:0]  ID_BASE       = 8'h30,
  parameter int unsigned STALL_TIMEOUT = 1024,
  parameter int unsigned CNT_W         = 11
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic                 tx_ready,
  output logic                 tx_en,
  output logic [7:0]           tx_data,
  output logic                 busy,
  output logic [1:0]           grant_id,
  output logic                 pkt_done,
  output logic                 abort_pulse
);

  localparam bit TIMEOUT_EN = (STALL_TIMEOUT != 0);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HDR  = 3'd1,
    S_ID   = 3'd2,
    S_PAY  = 3'd3
`ifdef UART_ARB_CHECKSUM_EN
    , S_CHK = 3'd4
`endif
  } state_t;

  state_t           r_state;
  logic [1:0]       r_grant;
  logic [1:0]       r_ptr;
  logic [CNT_W-1:0] r_stall_cnt;
  logic             r_busy;
  logic             r_pkt_done;
  logic             r_abort;
`ifdef UART_ARB_CHECKSUM_EN
  logic [7:0]       r_csum;
`endif

  logic       w_gvalid;
  logic [7:0] w_gdata;
  logic       w_glast;
  logic       w_any;
  logic [1:0] w_sel;
  logic [2:0] w_idx;
  logic [1:0] w_next_ptr;
  logic [7:0] w_id_byte;
  logic       w_timeout;
  logic       w_xfer;

  // Pick out the granted requester's valid/data/last without a variable part-select
  always_comb begin
    w_gvalid = 1'b0;
    w_gdata  = 8'h00;
    w_glast  = 1'b0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (r_grant == 2'(i)) begin
        w_gvalid = req_valid[i];
        w_gdata  = req_data[8*i +: 8];
        w_glast  = req_last[i];
      end
    end
  end

  // Round-robin search from r_ptr upward; the smallest offset with valid wins
  always_comb begin
    w_any = 1'b0;
    w_sel = r_ptr;
    w_idx = 3'd0;
    for (int k = int'(NUM_REQ) - 1; k >= 0; k--) begin
      w_idx = {1'b0, r_ptr} + 3'(k);
      if (w_idx >= 3'(NUM_REQ)) begin
        w_idx = w_idx - 3'(NUM_REQ);
      end
      for (int i = 0; i < int'(NUM_REQ); i++) begin
        if (req_valid[i] && (w_idx == 3'(i))) begin
          w_any = 1'b1;
          w_sel = w_idx[1:0];
        end
      end
    end
  end

  assign w_next_ptr = (r_grant == 2'(NUM_REQ - 1)) ? 2'd0 : r_grant + 2'd1;
  assign w_id_byte  = ID_BASE + {6'd0, r_grant};

  // The abort fires on the stall cycle that brings the count up to the limit
  assign w_timeout = TIMEOUT_EN && (r_state == S_PAY) && !w_gvalid &&
                     (r_stall_cnt == CNT_W'(STALL_TIMEOUT - 1));

  // Transmit strobe, byte mux and requester acknowledge from state and inputs
  always_comb begin
    tx_en     = 1'b0;
    tx_data   = 8'h00;
    req_ready = '0;
    case (r_state)
      S_HDR: begin
        tx_en   = tx_ready;
        tx_data = SYNC_BYTE;
      end
      S_ID: begin
        tx_en   = tx_ready;
        tx_data = w_id_byte;
      end
      S_PAY: begin
        tx_data = w_gdata;
        if (!w_timeout) begin
          tx_en = tx_ready & w_gvalid;
          for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (r_grant == 2'(i)) begin
              req_ready[i] = tx_ready;
            end
          end
        end
      end
`ifdef UART_ARB_CHECKSUM_EN
      S_CHK: begin
        tx_en   = tx_ready;
        tx_data = r_csum;
      end
`endif
      default: begin
      end
    endcase
  end

  assign w_xfer = tx_en;

  // Frame sequencer: arbitration, header/ID/payload progress, stall abort, pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_grant     <= 2'd0;
      r_ptr       <= 2'd0;
      r_stall_cnt <= '0;
      r_busy      <= 1'b0;
      r_pkt_done  <= 1'b0;
      r_abort     <= 1'b0;
`ifdef UART_ARB_CHECKSUM_EN
      r_csum      <= 8'h00;
`endif
    end else begin
      r_pkt_done <= 1'b0;
      r_abort    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_stall_cnt <= '0;
`ifdef UART_ARB_CHECKSUM_EN
          r_csum      <= 8'h00;
`endif
          if (w_any) begin
            r_grant <= w_sel;
            r_busy  <= 1'b1;
            r_state <= S_HDR;
          end
        end
        S_HDR: begin
          if (w_xfer) begin
            r_state <= S_ID;
          end
        end
        S_ID: begin
          if (w_xfer) begin
            r_state     <= S_PAY;
            r_stall_cnt <= '0;
`ifdef UART_ARB_CHECKSUM_EN
            r_csum      <= r_csum ^ w_id_byte;
`endif
          end
        end
        S_PAY: begin
          if (w_timeout) begin
            r_state     <= S_IDLE;
            r_abort     <= 1'b1;
            r_busy      <= 1'b0;
            r_ptr       <= w_next_ptr;
            r_stall_cnt <= '0;
          end else if (w_xfer) begin
            r_stall_cnt <= '0;
`ifdef UART_ARB_CHECKSUM_EN
            r_csum      <= r_csum ^ w_gdata;
`endif
            if (w_glast) begin
              r_ptr <= w_next_ptr;
`ifdef UART_ARB_CHECKSUM_EN
              r_state <= S_CHK;
`else
              r_state    <= S_IDLE;
              r_busy     <= 1'b0;
              r_pkt_done <= 1'b1;
`endif
            end
          end else if (!w_gvalid) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
          end
        end
`ifdef UART_ARB_CHECKSUM_EN
        S_CHK: begin
          if (w_xfer) begin
            r_state    <= S_IDLE;
            r_busy     <= 1'b0;
            r_pkt_done <= 1'b1;
          end
        end
`endif
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy        = r_busy;
  assign grant_id    = r_grant;
  assign pkt_done    = r_pkt_done;
  assign abort_pulse = r_abort;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter (two requesters, stall limit of 4 cycles).
// Directed per-cycle vector table, hand-written multi-cycle sequences and a
// randomized run scored against a frame-level round-robin reference model.
module tb_uart_tx_arbiter;

  localparam int NREQ = 2;
`ifdef UART_ARB_CHECKSUM_EN
  localparam int FRAME_EXTRA = 1;
`else
  localparam int FRAME_EXTRA = 0;
`endif

  logic        clk;
  logic        reset;
  logic [1:0]  req_valid;
  logic [15:0] req_data;
  logic [1:0]  req_last;
  logic [1:0]  req_ready;
  logic        tx_ready;
  logic        tx_en;
  logic [7:0]  tx_data;
  logic        busy;
  logic [1:0]  grant_id;
  logic        pkt_done;
  logic        abort_pulse;

  int compared;
  int mismatched;

  uart_tx_arbiter #(
    .NUM_REQ(NREQ),
    .SYNC_BYTE(8'hA5),
    .ID_BASE(8'h30),
    .STALL_TIMEOUT(4),
    .CNT_W(3)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req_valid(req_valid),
    .req_data(req_data),
    .req_last(req_last),
    .req_ready(req_ready),
    .tx_ready(tx_ready),
    .tx_en(tx_en),
    .tx_data(tx_data),
    .busy(busy),
    .grant_id(grant_id),
    .pkt_done(pkt_done),
    .abort_pulse(abort_pulse)
  );

  // 100 MHz clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] valid;
    logic [7:0] d0;
    logic [7:0] d1;
    logic [1:0] last;
    logic       txr;
    logic       expEn;
    logic [7:0] expData;
    logic       chkData;
    logic [1:0] expReady;
    logic       expBusy;
    logic       expDone;
    logic       expAbort;
    logic [1:0] expGrant;
  } vec_t;

  vec_t vecs[$];

  function automatic void addVec(input logic [1:0] v, input logic [7:0] a, input logic [7:0] b,
                                 input logic [1:0] l, input logic t, input logic en,
                                 input logic [7:0] d, input logic c, input logic [1:0] rdy,
                                 input logic bz, input logic dn, input logic ab,
                                 input logic [1:0] g);
    vec_t x;
    x.valid = v; x.d0 = a; x.d1 = b; x.last = l; x.txr = t;
    x.expEn = en; x.expData = d; x.chkData = c; x.expReady = rdy;
    x.expBusy = bz; x.expDone = dn; x.expAbort = ab; x.expGrant = g;
    vecs.push_back(x);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Drive a new input set just after the falling edge, then let outputs settle
  task automatic applyStimulus(input logic [1:0] v, input logic [7:0] a, input logic [7:0] b,
                               input logic [1:0] l, input logic t);
    @(negedge clk);
    req_valid = v;
    req_data  = {b, a};
    req_last  = l;
    tx_ready  = t;
    #1;
  endtask

  task automatic doReset();
    @(negedge clk);
    reset     = 1'b1;
    req_valid = 2'b00;
    req_data  = 16'h0000;
    req_last  = 2'b00;
    tx_ready  = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Reference-model state for the randomized run
  logic [8:0] pq [2][$];
  logic [7:0] expByte[$];
  int         expSrc[$];
  bit         expPay[$];
  int         npk[2];
  int         rem[2];
  int         mpos[2];
  int         dpos[2];
  int         gap[2];
  bit         gapCycle[2];
  int         plen;
  int         mptr;
  int         msel;
  int         frames;
  int         doneCnt;
  int         abortCnt;
  int         cyc;
  logic [7:0] csum;
  logic       hs;
  logic       expHs;
  logic [7:0] rrExp[$];
  int         rrSrc[$];
  int         got;
  int         frameLen;
  int         ph;
  logic [7:0] gapExp;

  initial begin
    compared   = 0;
    mismatched = 0;
    reset      = 1'b1;
    req_valid  = 2'b00;
    req_data   = 16'h0000;
    req_last   = 2'b00;
    tx_ready   = 1'b1;

    // ---------------- vector table ----------------
    // reset state
    addVec(2'b00, 8'h00, 8'h00, 2'b00, 1, 0, 8'h00, 0, 2'b00, 0, 0, 0, 2'd0);
    // single frame from req0: A5 30 11 22
    addVec(2'b01, 8'h11, 8'h00, 2'b00, 1, 0, 8'h00, 0, 2'b00, 0, 0, 0, 2'd0);
    addVec(2'b01, 8'h11, 8'h00, 2'b00, 1, 1, 8'hA5, 1, 2'b00, 1, 0, 0, 2'd0);
    addVec(2'b01, 8'h11, 8'h00, 2'b00, 1, 1, 8'h30, 1, 2'b00, 1, 0, 0, 2'd0);
    addVec(2'b01, 8'h11, 8'h00, 2'b00, 1, 1, 8'h11, 1, 2'b01, 1, 0, 0, 2'd0);
    addVec(2'b01, 8'h22, 8'h00, 2'b01, 1, 1, 8'h22, 1, 2'b01, 1, 0, 0, 2'd0);
`ifdef UART_ARB_CHECKSUM_EN
    addVec(2'b00, 8'h00, 8'h00, 2'b00, 1, 1, 8'h03, 1, 2'b00, 1, 0, 0, 2'd0);
`endif
    addVec(2'b00, 8'h00, 8'h00, 2'b00, 1, 0, 8'h00, 0, 2'b00, 0, 1, 0, 2'd0);
    addVec(2'b00, 8'h00, 8'h00, 2'b00, 1, 0, 8'h00, 0, 2'b00, 0, 0, 0, 2'd0);
    // req1 frame with 5 cycles of tx backpressure in the payload
    addVec(2'b10, 8'h00, 8'h44, 2'b00, 1, 0, 8'h00, 0, 2'b00, 0, 0, 0, 2'd0);
    addVec(2'b10, 8'h00, 8'h44, 2'b00, 1, 1, 8'hA5, 1, 2'b00, 1, 0, 0, 2'd1);
    addVec(2'b10, 8'h00, 8'h44, 2'b00, 1, 1, 8'h31, 1, 2'b00, 1, 0, 0, 2'd1);
    for (int i = 0; i < 5; i++)
      addVec(2'b10, 8'h00, 8'h44, 2'b00, 0, 0, 8'h44, 1, 2'b00, 1, 0, 0, 2'd1);
    addVec(2'b10, 8'h00, 8'h44, 2'b00, 1, 1, 8'h44, 1, 2'b10, 1, 0, 0, 2'd1);
    addVec(2'b10, 8'h00, 8'h55, 2'b10, 1, 1, 8'h55, 1, 2'b10, 1, 0, 0, 2'd1);
`ifdef UART_ARB_CHECKSUM_EN
    addVec(2'b00, 8'h00, 8'h00, 2'b00, 1, 1, 8'h20, 1, 2'b00, 1, 0, 0, 2'd1);
`endif
    addVec(2'b00, 8'h00, 8'h00, 2'b00, 1, 0, 8'h00, 0, 2'b00, 0, 1, 0, 2'd1);
    addVec(2'b00, 8'h00, 8'h00, 2'b00, 1, 0, 8'h00, 0, 2'b00, 0, 0, 0, 2'd1);
    // req1 stalls after one payload byte; req0 waits and must be ignored
    addVec(2'b10, 8'h00, 8'h66, 2'b00, 1, 0, 8'h00, 0, 2'b00, 0, 0, 0, 2'd1);
    addVec(2'b10, 8'h00, 8'h66, 2'b00, 1, 1, 8'hA5, 1, 2'b00, 1, 0, 0, 2'd1);
    addVec(2'b10, 8'h00, 8'h66, 2'b00, 1, 1, 8'h31, 1, 2'b00, 1, 0, 0, 2'd1);
    addVec(2'b10, 8'h00, 8'h66, 2'b00, 1, 1, 8'h66, 1, 2'b10, 1, 0, 0, 2'd1);
    for (int i = 0; i < 3; i++)
      addVec(2'b01, 8'h77, 8'h66, 2'b01, 1, 0, 8'h66, 1, 2'b10, 1, 0, 0, 2'd1);
    addVec(2'b01, 8'h77, 8'h66, 2'b01, 1, 0, 8'h66, 1, 2'b00, 1, 0, 0, 2'd1);
    // abort pulse; both valid, pointer now at req0
    addVec(2'b11, 8'h77, 8'h88, 2'b01, 1, 0, 8'h00, 0, 2'b00, 0, 0, 1, 2'd1);
    addVec(2'b11, 8'h77, 8'h88, 2'b01, 1, 1, 8'hA5, 1, 2'b00, 1, 0, 0, 2'd0);
    addVec(2'b11, 8'h77, 8'h88, 2'b01, 1, 1, 8'h30, 1, 2'b00, 1, 0, 0, 2'd0);
    addVec(2'b11, 8'h77, 8'h88, 2'b01, 1, 1, 8'h77, 1, 2'b01, 1, 0, 0, 2'd0);
`ifdef UART_ARB_CHECKSUM_EN
    addVec(2'b00, 8'h00, 8'h00, 2'b00, 1, 1, 8'h47, 1, 2'b00, 1, 0, 0, 2'd0);
`endif
    addVec(2'b00, 8'h00, 8'h00, 2'b00, 1, 0, 8'h00, 0, 2'b00, 0, 1, 0, 2'd0);

    doReset();
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].valid, vecs[i].d0, vecs[i].d1, vecs[i].last, vecs[i].txr);
      checkOutput($sformatf("vec%0d tx_en", i), tx_en, vecs[i].expEn);
      if (vecs[i].chkData)
        checkOutput($sformatf("vec%0d tx_data", i), tx_data, vecs[i].expData);
      checkOutput($sformatf("vec%0d req_ready", i), req_ready, vecs[i].expReady);
      checkOutput($sformatf("vec%0d busy", i), busy, vecs[i].expBusy);
      checkOutput($sformatf("vec%0d pkt_done", i), pkt_done, vecs[i].expDone);
      checkOutput($sformatf("vec%0d abort_pulse", i), abort_pulse, vecs[i].expAbort);
      checkOutput($sformatf("vec%0d grant_id", i), grant_id, vecs[i].expGrant);
    end

    // ---------------- round-robin, 1-byte packets from both ----------------
    for (int f = 0; f < 4; f++) begin
      rrExp.push_back(8'hA5);               rrSrc.push_back(f % 2);
      rrExp.push_back(8'(8'h30 + (f % 2))); rrSrc.push_back(f % 2);
      rrExp.push_back((f % 2) ? 8'hB1 : 8'hA0); rrSrc.push_back(f % 2);
`ifdef UART_ARB_CHECKSUM_EN
      rrExp.push_back((f % 2) ? 8'h80 : 8'h90); rrSrc.push_back(f % 2);
`endif
    end
    doReset();
    got = 0;
    for (int k = 0; k < 24; k++) begin
      applyStimulus(2'b11, 8'hA0, 8'hB1, 2'b11, 1);
      if (tx_en && got < rrExp.size()) begin
        checkOutput($sformatf("rr byte%0d", got), tx_data, rrExp[got]);
        checkOutput($sformatf("rr grant%0d", got), grant_id, 2'(rrSrc[got]));
        got++;
      end
    end
    checkOutput("rr byte count", got, rrExp.size());

    // ---------------- idle gap between back-to-back frames of req0 ----------------
    frameLen = 3 + FRAME_EXTRA;
    doReset();
    for (int k = 0; k < 2 * (frameLen + 1) + 1; k++) begin
      applyStimulus(2'b01, 8'hC3, 8'h00, 2'b01, 1);
      ph = k % (frameLen + 1);
      checkOutput($sformatf("gap k%0d tx_en", k), tx_en, (ph != 0));
      checkOutput($sformatf("gap k%0d pkt_done", k), pkt_done, (k > 0 && ph == 0));
      if (ph != 0) begin
        case (ph)
          1: gapExp = 8'hA5;
          2: gapExp = 8'h30;
          3: gapExp = 8'hC3;
          default: gapExp = 8'hF3;
        endcase
        checkOutput($sformatf("gap k%0d tx_data", k), tx_data, gapExp);
      end
    end

    // ---------------- reset in the middle of a req1 payload ----------------
    doReset();
    for (int k = 0; k < 5; k++) applyStimulus(2'b10, 8'h00, 8'hD0, 2'b00, 1);
    checkOutput("midrst pay tx_data", tx_data, 8'hD0);
    checkOutput("midrst pay req_ready", req_ready, 2'b10);
    @(negedge clk);
    reset = 1'b1;
    #1;
    @(negedge clk);
    reset     = 1'b0;
    req_valid = 2'b11;
    req_data  = {8'hD0, 8'hE0};
    req_last  = 2'b00;
    #1;
    checkOutput("midrst tx_en", tx_en, 0);
    checkOutput("midrst busy", busy, 0);
    checkOutput("midrst grant_id", grant_id, 2'd0);
    checkOutput("midrst req_ready", req_ready, 2'b00);
    applyStimulus(2'b11, 8'hE0, 8'hD0, 2'b00, 1);
    checkOutput("midrst hdr", tx_data, 8'hA5);
    checkOutput("midrst regrant", grant_id, 2'd0);
    applyStimulus(2'b11, 8'hE0, 8'hD0, 2'b00, 1);
    checkOutput("midrst id", tx_data, 8'h30);
    applyStimulus(2'b11, 8'hE0, 8'hD0, 2'b00, 1);
    checkOutput("midrst pay0", tx_data, 8'hE0);
    checkOutput("midrst ready0", req_ready, 2'b01);

    // ---------------- randomized run against frame-level model ----------------
    frames = 0;
    for (int r = 0; r < 2; r++) begin
      npk[r] = $urandom_range(2, 6);
      frames += npk[r];
      for (int p = 0; p < npk[r]; p++) begin
        plen = $urandom_range(1, 5);
        for (int b = 0; b < plen; b++) pq[r].push_back({(b == plen - 1), 8'($urandom)});
      end
      rem[r]  = npk[r];
      mpos[r] = 0;
      dpos[r] = 0;
      gap[r]  = 0;
    end
    mptr = 0;
    while (rem[0] + rem[1] > 0) begin
      msel = (rem[mptr] > 0) ? mptr : (1 - mptr);
      expByte.push_back(8'hA5); expSrc.push_back(msel); expPay.push_back(0);
      expByte.push_back(8'(8'h30 + msel)); expSrc.push_back(msel); expPay.push_back(0);
      csum = 8'(8'h30 + msel);
      do begin
        expByte.push_back(pq[msel][mpos[msel]][7:0]); expSrc.push_back(msel); expPay.push_back(1);
        csum ^= pq[msel][mpos[msel]][7:0];
        mpos[msel]++;
      end while (!pq[msel][mpos[msel] - 1][8]);
`ifdef UART_ARB_CHECKSUM_EN
      expByte.push_back(csum); expSrc.push_back(msel); expPay.push_back(0);
`endif
      rem[msel]--;
      mptr = 1 - msel;
    end

    doReset();
    doneCnt  = 0;
    abortCnt = 0;
    cyc      = 0;
    while (expByte.size() > 0 && cyc < 5000) begin
      @(negedge clk);
      for (int r = 0; r < 2; r++) begin
        gapCycle[r] = 1'b0;
        if (dpos[r] < pq[r].size() && gap[r] == 0) begin
          req_valid[r]        = 1'b1;
          req_data[8*r +: 8]  = pq[r][dpos[r]][7:0];
          req_last[r]         = pq[r][dpos[r]][8];
        end else begin
          req_valid[r]        = 1'b0;
          req_data[8*r +: 8]  = 8'($urandom);
          req_last[r]         = 1'($urandom);
          gapCycle[r]         = (gap[r] > 0);
        end
      end
      tx_ready = ($urandom_range(0, 9) < 7);
      #1;
      if (tx_en) begin
        checkOutput("rnd tx_en needs tx_ready", tx_ready, 1);
        checkOutput($sformatf("rnd byte cyc%0d", cyc), tx_data, expByte[0]);
        checkOutput($sformatf("rnd grant cyc%0d", cyc), grant_id, 2'(expSrc[0]));
      end
      for (int r = 0; r < 2; r++) begin
        hs    = req_valid[r] & req_ready[r];
        expHs = tx_en && expPay[0] && (expSrc[0] == r);
        if (hs || expHs) checkOutput($sformatf("rnd ack req%0d cyc%0d", r, cyc), hs, expHs);
        if (hs) begin
          gap[r] = pq[r][dpos[r]][8] ? 0 : $urandom_range(0, 2);
          dpos[r]++;
        end else if (gapCycle[r]) begin
          gap[r]--;
        end
      end
      if (tx_en) begin
        void'(expByte.pop_front());
        void'(expSrc.pop_front());
        void'(expPay.pop_front());
      end
      if (pkt_done) doneCnt++;
      if (abort_pulse) abortCnt++;
      cyc++;
    end
    for (int k = 0; k < 3; k++) begin
      applyStimulus(2'b00, 8'h00, 8'h00, 2'b00, 1);
      if (pkt_done) doneCnt++;
      if (abort_pulse) abortCnt++;
      checkOutput($sformatf("rnd tail%0d tx_en", k), tx_en, 0);
    end
    checkOutput("rnd bytes left", expByte.size(), 0);
    checkOutput("rnd pkt_done count", doneCnt, frames);
    checkOutput("rnd abort count", abortCnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Packet-level round-robin arbiter that shares one UART transmit path between NUM_REQ byte-stream requesters in the 100 MHz domain. Wraps each granted packet as SYNC_BYTE, source-ID byte, then payload, and drives the UART transmitter's write-enable/data inputs under its ready handshake. Aborts a packet whose owner stalls mid-packet, so one requester cannot lock the link.

Parameters:
NUM_REQ, 2, number of requesters (2..4)
SYNC_BYTE, 8'hA5, first byte of every frame
ID_BASE, 8'h30, source-ID byte = ID_BASE + requester index
STALL_TIMEOUT, 1024, max consecutive cycles the granted requester may hold req_valid low mid-payload; 0 disables the timeout
CNT_W, 11, stall counter width (must hold STALL_TIMEOUT)

Ports:
clk  in  1  system clock, 100 MHz
reset  in  1  synchronous, active-high reset
req_valid  in  NUM_REQ  per-requester byte valid
req_data  in  8*NUM_REQ  per-requester byte; requester i on bits [8i+7:8i]
req_last  in  NUM_REQ  marks final payload byte of the packet
req_ready  out  NUM_REQ  byte accepted when req_valid[i] & req_ready[i]
tx_ready  in  1  UART transmitter can accept a byte this cycle
tx_en  out  1  write strobe to UART transmitter
tx_data  out  8  byte to UART transmitter
busy  out  1  high from grant until frame end/abort
grant_id  out  2  index of current/last granted requester
pkt_done  out  1  one-cycle pulse when a frame completes normally
abort_pulse  out  1  one-cycle pulse when a frame is aborted by timeout

Behaviour:
- Reset (clk edge with reset=1): state IDLE; rr pointer 0; stall counter 0; busy, pkt_done, abort_pulse, grant_id all 0. tx_en, req_ready are 0 in IDLE.
- tx_en, tx_data, req_ready are combinational from state, grant register and inputs; a byte transfers to UART on any cycle tx_en=1. tx_en is never 1 while tx_ready=0.
- States: IDLE, HDR, ID, PAY, (CHK when macro enabled).
- IDLE: if any req_valid, select the first valid index searching ptr, ptr+1, ... mod NUM_REQ; register grant_id, busy<=1, go HDR next cycle. No bytes are taken in IDLE.
- HDR: tx_data=SYNC_BYTE, tx_en=tx_ready; on transfer -> ID.
- ID: tx_data=ID_BASE+grant_id, tx_en=tx_ready; on transfer -> PAY.
- PAY: g=grant_id; tx_data=req_data[g]; tx_en=tx_ready & req_valid[g]; req_ready[g]=tx_ready; other req_ready bits 0. On transfer with req_last[g]: -> IDLE (or CHK), pkt_done pulses the cycle after (when going to IDLE), busy<=0, ptr<=(g+1) mod NUM_REQ.
- Stall counter (PAY only): cleared on each transfer and on PAY entry; increments on cycles where req_valid[g]=0; cycles with req_valid[g]=1 and tx_ready=0 are not stalls and hold the counter. When counter reaches STALL_TIMEOUT (and STALL_TIMEOUT!=0): -> IDLE, abort_pulse for one cycle, busy<=0, ptr<=g+1; no checksum emitted; no req_ready asserted that cycle.
- Non-granted requesters are never acknowledged; their req_valid changes are ignored until re-arbitration.
- Back-to-back: after frame end, IDLE spends exactly one cycle before the next HDR; min inter-frame gap 1 cycle.
- Single requester always valid: it is regranted every frame (ptr skips invalid indices).
- tx_ready low for any duration in HDR/ID/CHK: state holds, no timeout.
- reset asserted mid-frame: immediate return to IDLE on that edge; partial frame is not completed.
- 1-byte payload (req_last on first byte) is legal.

Optional Feature:
UART_ARB_CHECKSUM_EN: when defined, a running XOR register (cleared in IDLE) accumulates the ID byte and every transferred payload byte; after the last payload byte the FSM enters CHK, drives tx_data=checksum, tx_en=tx_ready, and on transfer -> IDLE with pkt_done. When undefined, CHK and the XOR register do not exist; the frame ends after the last payload byte.

Test Plan:
- Single frame: req0 sends 8'h11,8'h22(last), tx_ready=1 -> tx stream A5,30,11,22 on 4 consecutive tx_en cycles; pkt_done 1 cycle; with macro, 5th byte 8'h03 (30^11^22).
- Round-robin: req0 and req1 both continuously valid, 1-byte packets -> frames alternate source IDs 30,31,30,31; grant_id toggles.
- Backpressure: tx_ready low 5 cycles during PAY -> tx_en=0 and req_ready=0 for those cycles, no abort, byte order preserved.
- Stall abort: STALL_TIMEOUT=4, req1 drops req_valid after first payload byte -> abort_pulse after exactly 4 stall cycles, busy=0, next grant goes to req0 if valid.
- Reset mid-frame: reset during PAY of req1 -> next cycle IDLE, tx_en=0, ptr=0; a subsequent request from both grants req0 first.
- Idle gap: two back-to-back packets from req0 only -> exactly one cycle with tx_en=0 between last byte and next A5.
